// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit: operation selects and FSM states.
package muldiv_unit_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    MDS_IDLE = 2'd0,
    MDS_MUL  = 2'd1,
    MDS_DIV  = 2'd2,
    MDS_FIX  = 2'd3
  } md_state_e;

endpackage

// File: rtl/md_signfix.sv
// Conditional two's-complement negate, used both to take operand magnitudes and to
// restore the sign of mul/div results.
module md_signfix #(
  parameter int unsigned W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? ((~din) + W'(1)) : din;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle shift-add multiply / restoring divide with architectural HI/LO registers.
// Operates on magnitudes; signs are applied in a single FIX cycle before HI/LO are written.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Start,
  input  logic [2:0]      Op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            Busy,
  output logic            Done,
  output logic            DivByZero,
  output logic [XLEN-1:0] HI,
  output logic [XLEN-1:0] LO
);

  localparam int unsigned     CntW    = $clog2(XLEN);
  localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);

  md_state_e state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  // MUL: {product high, multiplier/product low}; DIV: {remainder, dividend/quotient}.
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              neg_q, neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic              is_div_q, is_div_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic              done_q, done_d;
  logic              dbz_q, dbz_d;

  logic              signed_op, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  logic [XLEN-1:0]   mul_addend;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift, div_diff;
  logic [2*XLEN-1:0] div_next;

  assign signed_op = (Op == MD_MULT) || (Op == MD_DIV);
  assign a_neg     = signed_op & A[XLEN-1];
  assign b_neg     = signed_op & B[XLEN-1];

  md_signfix #(.W(XLEN)) u_a_mag (.neg(a_neg), .din(A), .dout(a_mag));
  md_signfix #(.W(XLEN)) u_b_mag (.neg(b_neg), .din(B), .dout(b_mag));

  md_signfix #(.W(2*XLEN)) u_prod_fix (.neg(neg_q), .din(acc_q), .dout(prod_fix));
  md_signfix #(.W(XLEN)) u_quo_fix (
    .neg (neg_q),
    .din (acc_q[XLEN-1:0]),
    .dout(quo_fix)
  );
  md_signfix #(.W(XLEN)) u_rem_fix (
    .neg (rem_neg_q),
    .din (acc_q[2*XLEN-1:XLEN]),
    .dout(rem_fix)
  );

  // One shift-add step: conditionally add multiplicand to the high half, then shift right.
  assign mul_addend = acc_q[0] ? opnd_q : '0;
  assign mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
  assign mul_next   = {mul_sum, acc_q[XLEN-1:1]};

  // One restoring step: a borrow out of the trial subtract keeps the shifted remainder.
  assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    is_div_d  = is_div_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;

    unique case (state_q)
      MDS_IDLE: begin
        if (Start) begin
          case (Op)
            MD_MTHI: hi_d = A;
            MD_MTLO: lo_d = A;
            MD_MULT, MD_MULTU: begin
              acc_d     = {{XLEN{1'b0}}, b_mag};
              opnd_d    = a_mag;
              neg_d     = a_neg ^ b_neg;
              rem_neg_d = 1'b0;
              is_div_d  = 1'b0;
              cnt_d     = '0;
              state_d   = MDS_MUL;
            end
            MD_DIV, MD_DIVU: begin
              if (B == '0) begin
                done_d = 1'b1;
                dbz_d  = 1'b1;
              end else begin
                acc_d     = {{XLEN{1'b0}}, a_mag};
                opnd_d    = b_mag;
                neg_d     = a_neg ^ b_neg;
                rem_neg_d = a_neg;
                is_div_d  = 1'b1;
                cnt_d     = '0;
                state_d   = MDS_DIV;
              end
            end
            default: ;
          endcase
        end
      end
      MDS_MUL, MDS_DIV: begin
        acc_d = (state_q == MDS_DIV) ? div_next : mul_next;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) state_d = MDS_FIX;
      end
      MDS_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*XLEN-1:XLEN];
          lo_d = prod_fix[XLEN-1:0];
        end
        done_d  = 1'b1;
        state_d = MDS_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= MDS_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      is_div_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      is_div_q  <= is_div_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign Busy      = (state_q != MDS_IDLE);
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: per-cycle comparison against a latency/arithmetic model,
// plus literal expectations for the key results.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int XLEN = 32;

  logic            CLK;
  logic            RST;
  logic            Start;
  logic [2:0]      Op;
  logic [XLEN-1:0] A, B;
  logic            Busy, Done, DivByZero;
  logic [XLEN-1:0] HI, LO;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .Start    (Start),
    .Op       (Op),
    .A        (A),
    .B        (B),
    .Busy     (Busy),
    .Done     (Done),
    .DivByZero(DivByZero),
    .HI       (HI),
    .LO       (LO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: results from plain arithmetic, timing from the cycle counts alone.
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit          m_done = 1'b0, m_dbz = 1'b0;
  int          m_left = 0;

  task automatic predict(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo);
    longint          sa, sb, sp, sq, sr;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = '0;
    lo = '0;
    case (op)
      MD_MULT: begin
        sp = sa * sb;
        hi = sp[63:32];
        lo = sp[31:0];
      end
      MD_MULTU: begin
        up = 64'(a) * 64'(b);
        hi = up[63:32];
        lo = up[31:0];
      end
      MD_DIV: begin
        sq = sa / sb;
        sr = sa % sb;
        hi = sr[31:0];
        lo = sq[31:0];
      end
      default: begin
        hi = a % b;
        lo = a / b;
      end
    endcase
  endtask

  always @(posedge CLK) begin
    m_done = 1'b0;
    m_dbz  = 1'b0;
    if (RST) begin
      m_hi   = '0;
      m_lo   = '0;
      m_left = 0;
    end else if (m_left != 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi   = p_hi;
        m_lo   = p_lo;
        m_done = 1'b1;
      end
    end else if (Start) begin
      if (Op == MD_MTHI) m_hi = A;
      else if (Op == MD_MTLO) m_lo = A;
      else if ((Op == MD_DIV || Op == MD_DIVU) && B == 0) begin
        m_done = 1'b1;
        m_dbz  = 1'b1;
      end else if (Op <= MD_DIVU) begin
        predict(Op, A, B, p_hi, p_lo);
        m_left = XLEN + 1;
      end
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("busy", 32'(Busy), 32'(m_left != 0));
      chk("done", 32'(Done), 32'(m_done));
      chk("divbyzero", 32'(DivByZero), 32'(m_dbz));
      chk("hi", HI, m_hi);
      chk("lo", LO, m_lo);
    end
  end

  // Called at a negedge; Start is sampled at the next posedge. Returns in cycle k+1.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    @(negedge CLK);
    Start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!Done && cyc < 100) begin
      @(negedge CLK);
      cyc++;
    end
    if (!Done) chk("done_timeout", 32'(Done), 32'd1);
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int cyc;
    issue(op, a, b);
    wait_done(cyc);
    chk({name, "_latency"}, 32'(cyc), 32'd34);
    chk({name, "_hi"}, HI, ehi);
    chk({name, "_lo"}, LO, elo);
  endtask

  initial begin
    int cyc;
    int done_seen;
    RST   = 1'b1;
    Start = 1'b0;
    Op    = '0;
    A     = '0;
    B     = '0;
    repeat (2) @(negedge CLK);
    cmp_en = 1'b1;
    chk("reset_hi", HI, 32'h0);
    chk("reset_lo", LO, 32'h0);
    chk("reset_busy", 32'(Busy), 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    run_op("mult_neg", MD_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    // Issued in the Done cycle of the previous op; HI/LO must hold until completion.
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (5) @(negedge CLK);
    chk("multu_hold_hi", HI, 32'hFFFF_FFFF);
    chk("multu_hold_lo", LO, 32'hFFFF_FFEB);
    chk("multu_busy", 32'(Busy), 32'd1);
    wait_done(cyc);
    chk("multu_hi", HI, 32'hFFFF_FFFE);
    chk("multu_lo", LO, 32'h0000_0001);

    run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", MD_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
    run_op("mult_negneg", MD_MULT, 32'hFFFF_FFF0, 32'hFFFF_FFFE, 32'h0, 32'h20);
    run_op("divu_big", MD_DIVU, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF);
    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    @(negedge CLK);

    issue(MD_DIV, 32'd5, 32'd0);
    chk("dbz_done", 32'(Done), 32'd1);
    chk("dbz_flag", 32'(DivByZero), 32'd1);
    chk("dbz_busy", 32'(Busy), 32'd0);
    chk("dbz_hi", HI, 32'h0);
    chk("dbz_lo", LO, 32'h8000_0000);
    @(negedge CLK);
    chk("dbz_done_drop", 32'(Done), 32'd0);

    issue(3'd6, 32'hDEAD_BEEF, 32'd1);
    chk("undef_busy", 32'(Busy), 32'd0);
    chk("undef_hi", HI, 32'h0);

    // Abort a MULT by reset; a Start issued mid-operation must be ignored.
    issue(MD_MULT, 32'd3, 32'd5);
    repeat (4) @(negedge CLK);
    issue(MD_DIVU, 32'd100, 32'd3);
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    done_seen = 0;
    repeat (40) begin
      @(negedge CLK);
      if (Done) done_seen++;
    end
    chk("rst_no_done", 32'(done_seen), 32'd0);

    issue(MD_MTHI, 32'h1234, 32'd0);
    chk("mthi_hi", HI, 32'h1234);
    issue(MD_MTLO, 32'h5678, 32'd0);
    chk("mtlo_hi", HI, 32'h1234);
    chk("mtlo_lo", LO, 32'h5678);
    chk("mt_done", 32'(Done), 32'd0);
    repeat (2) @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
